// File: rtl/aes_selftest_ctrl_pkg.sv
// Shared types, LED bit positions and the AES-128 known-answer ROM
// used by the AES self-test controller.
package aes_selftest_pkg;

    localparam int NUM_VECTORS_MAX = 8;

    localparam int LED_READY = 7;
    localparam int LED_PASS  = 6;
    localparam int LED_FAIL  = 5;
    localparam int LED_DEC   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_e;

    typedef logic [127:0] block_t;

    typedef struct packed {
        logic       fail;
        logic       timeout;
        logic [3:0] pass_cnt;
    } status_t;

    // 0: FIPS-197 C.1, 1: FIPS-197 B, 2-5: SP800-38A ECB-AES128, 6-7: zero-key vectors
    localparam block_t KAT_KEY [NUM_VECTORS_MAX] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'h00000000000000000000000000000000,
        128'h00000000000000000000000000000000
    };

    localparam block_t KAT_PT [NUM_VECTORS_MAX] = '{
        128'h00112233445566778899aabbccddeeff,
        128'h3243f6a8885a308d313198a2e0370734,
        128'h6bc1bee22e409f96e93d7e117393172a,
        128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef,
        128'hf69f2445df4f9b17ad2b417be66c3710,
        128'h00000000000000000000000000000000,
        128'hf34481ec3cc627bacd5dc3fb08f273e6
    };

    localparam block_t KAT_CT [NUM_VECTORS_MAX] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h3925841d02dc09fbdc118597196a0b32,
        128'h3ad77bb40d7a3660a89ecaf32466ef97,
        128'hf5d3d58503b9699de785895a96fdbaaf,
        128'h43b1cd7f598ece23881b00e3ed030688,
        128'h7b0c785e27e8ad3f8223207104725dd4,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
        128'h0336763e966d92595a567cc9ce537f5e
    };

    function automatic block_t kat_key(input logic [2:0] idx);
        return KAT_KEY[idx];
    endfunction

    // Block fed to the core: plaintext when encrypting, ciphertext when decrypting.
    function automatic block_t kat_input(input logic [2:0] idx, input logic dec);
        return dec ? KAT_CT[idx] : KAT_PT[idx];
    endfunction

    function automatic block_t kat_expect(input logic [2:0] idx, input logic dec);
        return dec ? KAT_PT[idx] : KAT_CT[idx];
    endfunction

endpackage

// File: rtl/aes_selftest_ctrl_if.sv
// Start/done handshake and data buses between the self-test controller
// and the external iterative AES-128 core.
interface aes_selftest_ctrl_if;
    import aes_selftest_pkg::*;

    logic   core_start;
    logic   core_decrypt;
    block_t core_key;
    block_t core_din;
    block_t core_dout;
    logic   core_done;

    modport master (
        output core_start,
        output core_decrypt,
        output core_key,
        output core_din,
        input  core_dout,
        input  core_done
    );

    modport slave (
        input  core_start,
        input  core_decrypt,
        input  core_key,
        input  core_din,
        output core_dout,
        output core_done
    );

endinterface

// File: rtl/aes_selftest_ctrl_btn_debounce.sv
// Raw button to clean one-cycle press pulse: 2-FF synchroniser, level
// debouncer requiring DEBOUNCE_CYCLES stable cycles, rising-edge detect.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any bounce back restarts it from zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/aes_selftest_ctrl.sv
// Known-answer self-test controller for an external iterative AES-128 core:
// runs one or all ROM vectors, checks results, reports status on 8 LEDs.
module aes_selftest_ctrl
    import aes_selftest_pkg::*;
#(
    parameter int NUM_VECTORS     = 4,
    parameter int SW_W            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btnC,
    input  logic                btnU,
    input  logic [SW_W-1:0]     sw,
    output logic [7:0]          led,
    aes_selftest_ctrl_if.master core
);

    localparam int IDX_W = SW_W - 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       start_p;
    logic       mode_p;

    assign btn_raw = {btnU, btnC};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn_i  (btn_raw[gi]),
                .pulse_o(btn_pulse[gi])
            );
        end
    endgenerate

    assign start_p = btn_pulse[0];
    assign mode_p  = btn_pulse[1];

    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic             sweep_q, sweep_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    status_t          status_q, status_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    block_t           dout_q, dout_d;
    block_t           key_q, key_d;
    block_t           din_q, din_d;
    logic             start_q, start_d;
    logic [7:0]       led_q, led_d;

    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] next_idx;
    block_t           exp_blk;

    assign sel_idx  = sw_sync_q[SW_W-1] ? '0 : sw_sync_q[SW_W-2:0];
    assign next_idx = idx_q + IDX_W'(1);
    assign exp_blk  = kat_expect(3'(idx_q), mode_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sweep_d   = sweep_q;
        idx_d     = idx_q;
        status_d  = status_q;
        tmo_cnt_d = tmo_cnt_q;
        dout_d    = dout_q;
        key_d     = key_q;
        din_d     = din_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (mode_p) begin
                    mode_d = ~mode_q;
                end
                if (start_p) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sweep_d  = sw_sync_q[SW_W-1];
                idx_d    = sel_idx;
                status_d = '0;
                if (sel_idx > LAST_IDX) begin
                    status_d.fail = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    key_d   = kat_key(3'(sel_idx));
                    din_d   = kat_input(3'(sel_idx), mode_q);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tmo_cnt_d = TMO_W'(1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A done landing on the expiry cycle still wins over the timeout.
                if (core.core_done) begin
                    dout_d  = core.core_dout;
                    state_d = ST_CHECK;
                end else if (tmo_cnt_q >= TMO_LIMIT) begin
                    status_d.timeout = 1'b1;
                    status_d.fail    = 1'b1;
                    state_d          = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (dout_q == exp_blk) begin
                    if (status_q.pass_cnt != 4'hF) begin
                        status_d.pass_cnt = status_q.pass_cnt + 4'd1;
                    end
                end else begin
                    status_d.fail = 1'b1;
                end
                if (sweep_q && (idx_q < LAST_IDX)) begin
                    idx_d   = next_idx;
                    key_d   = kat_key(3'(next_idx));
                    din_d   = kat_input(3'(next_idx), mode_q);
                    state_d = ST_START;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d = (state_d == ST_START);

        led_d            = '0;
        led_d[LED_READY] = (state_d == ST_IDLE) || (state_d == ST_DONE);
        led_d[LED_PASS]  = (state_d == ST_DONE) && !status_d.fail && !status_d.timeout;
        led_d[LED_FAIL]  = status_d.fail;
        led_d[LED_DEC]   = mode_d;
        led_d[3:0]       = status_d.pass_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            sweep_q   <= 1'b0;
            idx_q     <= '0;
            status_q  <= '0;
            tmo_cnt_q <= '0;
            dout_q    <= '0;
            key_q     <= '0;
            din_q     <= '0;
            start_q   <= 1'b0;
            led_q     <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            state_q   <= state_d;
            mode_q    <= mode_d;
            sweep_q   <= sweep_d;
            idx_q     <= idx_d;
            status_q  <= status_d;
            tmo_cnt_q <= tmo_cnt_d;
            dout_q    <= dout_d;
            key_q     <= key_d;
            din_q     <= din_d;
            start_q   <= start_d;
            led_q     <= led_d;
        end
    end

    assign core.core_start   = start_q;
    assign core.core_decrypt = mode_q;
    assign core.core_key     = key_q;
    assign core.core_din     = din_q;
    assign led               = led_q;

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Self-checking bench: behavioural 12-cycle AES core answering from a KAT
// lookup, a table of directed runs, plus glitch, timeout and reset sequences.
module tb_aes_selftest_ctrl;

    localparam int NUM_VECTORS     = 4;
    localparam int SW_W            = 4;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int TIMEOUT_CYCLES  = 1024;
    localparam int CORE_LAT        = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnC = 1'b0;
    logic       btnU = 1'b0;
    logic [3:0] sw = 4'h0;
    logic [7:0] led;

    aes_selftest_ctrl_if bus ();

    aes_selftest_ctrl #(
        .NUM_VECTORS    (NUM_VECTORS),
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btnC(btnC),
        .btnU(btnU),
        .sw  (sw),
        .led (led),
        .core(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        bit         dec;
        int         corrupt;
        bit         no_done;
        int         first_idx;
        int         exp_starts;
        logic [7:0] exp_led;
    } vec_t;

    vec_t         vecs [10];
    logic [127:0] tb_key [4];
    logic [127:0] tb_pt  [4];
    logic [127:0] tb_ct  [4];

    int checks = 0;
    int errors = 0;

    int corrupt_idx = -1;
    bit no_done = 1'b0;
    bit inject  = 1'b0;

    int           cyc = 0;
    int           start_cnt = 0;
    int           start_cyc [256];
    logic [127:0] start_key [256];
    logic [127:0] start_din [256];
    logic         start_dec [256];
    bit           busy = 1'b0;
    int           lat = 0;
    logic [127:0] res = '0;

    function automatic logic [7:0] slot(input int v);
        return v[7:0];
    endfunction

    function automatic logic [127:0] core_calc(input logic [127:0] k, input logic [127:0] d,
                                               input logic dec, input int bad);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) begin
            if (tb_key[i] == k && (dec ? (tb_ct[i] == d) : (tb_pt[i] == d))) begin
                r = dec ? tb_pt[i] : tb_ct[i];
                if (i == bad) r[0] = ~r[0];
                return r;
            end
        end
        return '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Core answers 13 cycles after the start pulse, giving a 15-cycle sweep period.
    always @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            bus.core_done <= 1'b0;
            bus.core_dout <= '0;
        end else begin
            bus.core_done <= inject;
            if (bus.core_start) begin
                start_cnt                  <= start_cnt + 1;
                start_cyc[slot(start_cnt)] <= cyc;
                start_key[slot(start_cnt)] <= bus.core_key;
                start_din[slot(start_cnt)] <= bus.core_din;
                start_dec[slot(start_cnt)] <= bus.core_decrypt;
                busy <= 1'b1;
                lat  <= CORE_LAT;
                res  <= core_calc(bus.core_key, bus.core_din, bus.core_decrypt, corrupt_idx);
            end else if (busy) begin
                if (lat == 1) begin
                    busy <= 1'b0;
                    if (!no_done) begin
                        bus.core_done <= 1'b1;
                        bus.core_dout <= res;
                    end
                end else begin
                    lat <= lat - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        btnU = 1'b1;
        tick(8);
        btnU = 1'b0;
        tick(8);
    endtask

    // Hold btnC for 8 cycles and wait for the controller to leave and re-enter ready.
    task automatic launch(input int max_cyc, output bit ok);
        bit left;
        left = 1'b0;
        ok   = 1'b0;
        btnC = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (i == 7) btnC = 1'b0;
            if (!led[7]) left = 1'b1;
            else if (left && i >= 7) begin
                ok = 1'b1;
                break;
            end
        end
        btnC = 1'b0;
        tick(8);
    endtask

    initial begin
        int   base;
        bit   ok;
        bit   mode_tb;
        vec_t v;

        tb_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        tb_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        tb_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tb_key[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tb_pt[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        tb_ct[1]  = 128'h3925841d02dc09fbdc118597196a0b32;
        tb_key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tb_pt[2]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        tb_ct[2]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        tb_key[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tb_pt[3]  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        tb_ct[3]  = 128'hf5d3d58503b9699de785895a96fdbaaf;

        //           sw     dec corrupt no_done first starts led
        vecs[0] = '{4'h0, 1'b0, -1, 1'b0, 0, 1, 8'hC1};
        vecs[1] = '{4'h1, 1'b1, -1, 1'b0, 1, 1, 8'hD1};
        vecs[2] = '{4'h8, 1'b0, -1, 1'b0, 0, 4, 8'hC4};
        vecs[3] = '{4'h8, 1'b0,  2, 1'b0, 0, 4, 8'hA3};
        vecs[4] = '{4'h7, 1'b0, -1, 1'b0, 0, 0, 8'hA0};
        vecs[5] = '{4'h3, 1'b1, -1, 1'b0, 3, 1, 8'hD1};
        vecs[6] = '{4'h8, 1'b1, -1, 1'b0, 0, 4, 8'hD4};
        vecs[7] = '{4'h2, 1'b0,  2, 1'b0, 2, 1, 8'hA0};
        vecs[8] = '{4'h4, 1'b0, -1, 1'b0, 0, 0, 8'hA0};
        vecs[9] = '{4'h0, 1'b0, -1, 1'b1, 0, 1, 8'hA0};

        rst = 1'b1;
        tick(3);
        check("reset_led", 128'(led), 128'h0);
        check("reset_core_start", 128'(bus.core_start), 128'h0);
        check("reset_core_decrypt", 128'(bus.core_decrypt), 128'h0);
        check("reset_core_key", bus.core_key, 128'h0);
        check("reset_core_din", bus.core_din, 128'h0);
        rst = 1'b0;
        tick(3);
        check("idle_led", 128'(led), 128'h80);

        mode_tb = 1'b0;
        for (int n = 0; n < 10; n++) begin
            v           = vecs[n];
            sw          = v.sw;
            corrupt_idx = v.corrupt;
            no_done     = v.no_done;
            if (v.dec != mode_tb) begin
                press_mode();
                mode_tb = v.dec;
                check("mode_led", 128'(led[4]), 128'(v.dec));
            end
            base = start_cnt;
            launch(3000, ok);
            $display("vec %0d: sw=%h dec=%0d led=%h starts=%0d", n, v.sw, v.dec, led, start_cnt - base);
            check("done_reached", 128'(ok), 128'h1);
            check("led", 128'(led), 128'(v.exp_led));
            check("start_count", 128'(start_cnt - base), 128'(v.exp_starts));
            for (int k = 0; k < v.exp_starts; k++) begin
                check("core_key", start_key[slot(base + k)], tb_key[v.first_idx + k]);
                check("core_din", start_din[slot(base + k)],
                      v.dec ? tb_ct[v.first_idx + k] : tb_pt[v.first_idx + k]);
                check("core_decrypt", 128'(start_dec[slot(base + k)]), 128'(v.dec));
                if (k > 0) begin
                    check("start_spacing",
                          128'(start_cyc[slot(base + k)] - start_cyc[slot(base + k - 1)]), 128'd15);
                end
            end
        end

        // Short btnC glitch in DONE must not start a run.
        no_done     = 1'b0;
        corrupt_idx = -1;
        sw          = 4'h0;
        base        = start_cnt;
        btnC = 1'b1;
        tick(3);
        btnC = 1'b0;
        tick(20);
        $display("glitch: led=%h starts=%0d", led, start_cnt - base);
        check("glitch_starts", 128'(start_cnt - base), 128'h0);
        check("glitch_led", 128'(led), 128'hA0);

        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(5);
        $display("stray done: led=%h", led);
        check("stray_done_led", 128'(led), 128'hA0);

        press_mode();
        $display("mode toggle: led=%h", led);
        check("mode_done_led", 128'(led), 128'hB0);

        // Start a run that never completes, press btnC mid-WAIT, then reset.
        no_done = 1'b1;
        base    = start_cnt;
        btnC = 1'b1;
        tick(8);
        btnC = 1'b0;
        tick(8);
        check("wait_started", 128'(start_cnt - base), 128'h1);
        check("wait_led_busy", 128'(led[7]), 128'h0);
        btnC = 1'b1;
        tick(8);
        btnC = 1'b0;
        tick(8);
        $display("btnC in WAIT: led=%h starts=%0d", led, start_cnt - base);
        check("wait_no_restart", 128'(start_cnt - base), 128'h1);
        rst = 1'b1;
        #1;
        $display("reset in WAIT: led=%h core_start=%0d", led, bus.core_start);
        check("rst_wait_led", 128'(led), 128'h0);
        check("rst_wait_core_start", 128'(bus.core_start), 128'h0);
        check("rst_wait_core_key", bus.core_key, 128'h0);
        check("rst_wait_core_din", bus.core_din, 128'h0);
        check("rst_wait_core_decrypt", 128'(bus.core_decrypt), 128'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("post_rst_idle_led", 128'(led), 128'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
